// File: rtl/uart_tx_if.sv
// uart_tx_if: character request handshake between a producer and the UART transmitter.
interface uart_tx_if;
    logic [7:0] data;
    logic       valid;
    logic       ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/uart_tx.sv
// uart_tx: configurable 5-8 bit UART transmitter with optional parity, 1/2 stop bits and run-time baud select.
// Define UART_TX_HANDSHAKE_EN to gate each frame's start bit on cts when controls[4] is set.
module uart_tx #(
    parameter int CLK_FREQ = 50_000_000
) (
    input  logic       clk,
    input  logic       rst,
    uart_tx_if.slave   bus,
    input  logic [7:0] controls,
    input  logic       cts,
    output logic       tx,
    output logic       done
);
    localparam int CW = $clog2(CLK_FREQ / 7200 + 1);

    typedef enum logic [2:0] {
        IDLE,
`ifdef UART_TX_HANDSHAKE_EN
        WAIT_CTS,
`endif
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n, reload;
    logic [2:0]    idx, idx_n;
    logic          stp, stp_n, tx_n, done_n, accept, last, par;
    logic [7:0]    dat, ctl;
    logic          unused_ok;

    // Divider reload value (DIV-1) for a baud select field.
    function automatic logic [CW-1:0] div_m1(input logic [1:0] b);
        return b == 2'd0 ? CW'(CLK_FREQ / 7200 - 1) :
               b == 2'd1 ? CW'(CLK_FREQ / 9600 - 1) :
               b == 2'd2 ? CW'(CLK_FREQ / 19200 - 1) : CW'(CLK_FREQ / 115200 - 1);
    endfunction

    assign bus.ready = state == IDLE;
    assign accept    = bus.valid & bus.ready;
    assign reload    = div_m1(ctl[7:6]);
    assign last      = cnt == '0;
    assign par       = ^dat ^ ~ctl[1];
    assign unused_ok = ctl[4] ^ cts ^ controls[4];

    always_comb begin
        state_n = state;
        cnt_n   = last ? reload : cnt - CW'(1);
        idx_n   = idx;
        stp_n   = stp;
        done_n  = 1'b0;
        case (state)
            IDLE: begin
                cnt_n = accept ? div_m1(controls[7:6]) : '0;
                idx_n = 3'd0;
                stp_n = 1'b0;
`ifdef UART_TX_HANDSHAKE_EN
                if (accept) state_n = controls[4] ? WAIT_CTS : START;
            end
            WAIT_CTS: begin
                cnt_n = reload;
                if (cts) state_n = START;
`else
                if (accept) state_n = START;
`endif
            end
            START:  if (last) state_n = DATA;
            DATA: begin
                if (last && idx == 3'd4 + {1'b0, ctl[3:2]}) state_n = ctl[0] ? PARITY : STOP;
                else if (last) idx_n = idx + 3'd1;
            end
            PARITY: if (last) state_n = STOP;
            STOP: begin
                if (last && ctl[5] && !stp) stp_n = 1'b1;
                else if (last) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
        tx_n = state_n == START  ? 1'b0 :
               state_n == DATA   ? dat[idx_n] :
               state_n == PARITY ? par : 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= 3'd0;
            stp   <= 1'b0;
            tx    <= 1'b1;
            done  <= 1'b0;
            dat   <= 8'd0;
            ctl   <= 8'd0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            idx   <= idx_n;
            stp   <= stp_n;
            tx    <= tx_n;
            done  <= done_n;
            if (accept) begin
                dat <= bus.data & (8'hFF >> (2'd3 - controls[3:2]));
                ctl <= controls;
            end
        end
    end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: randomized and directed checks of uart_tx against a frame-level reference model.
module tb_uart_tx;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] controls = 8'd0;
    logic       cts = 1'b1;
    logic       tx, done;
    int         nvec = 0;
    int         nerr = 0;
    bit         exp_q[$];

    uart_tx_if bus();

    uart_tx #(.CLK_FREQ(460800)) dut (
        .clk(clk), .rst(rst), .bus(bus), .controls(controls), .cts(cts), .tx(tx), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int divof(input logic [7:0] c);
        int baud;
        baud = c[7:6] == 2'd0 ? 7200 : c[7:6] == 2'd1 ? 9600 : c[7:6] == 2'd2 ? 19200 : 115200;
        return 460800 / baud;
    endfunction

    function automatic int hs_wait(input logic [7:0] c);
`ifdef UART_TX_HANDSHAKE_EN
        return int'(c[4]);
`else
        return 0;
`endif
    endfunction

    // Expected per-cycle tx levels of one frame, preceded by any cts wait cycles.
    function automatic void build(input logic [7:0] c, input logic [7:0] d, input int waits);
        int n = 5 + int'(c[3:2]);
        int dv = divof(c);
        int ones = 0;
        bit seq[$];
        exp_q.delete();
        for (int i = 0; i < waits; i++) exp_q.push_back(1'b1);
        seq.push_back(1'b0);
        for (int i = 0; i < n; i++) begin
            seq.push_back(d[i]);
            ones += int'(d[i]);
        end
        if (c[0]) seq.push_back(c[1] ? bit'(ones % 2) : bit'(1 - ones % 2));
        seq.push_back(1'b1);
        if (c[5]) seq.push_back(1'b1);
        foreach (seq[k]) for (int j = 0; j < dv; j++) exp_q.push_back(seq[k]);
    endfunction

    task automatic check_frame(input logic [7:0] c, input logic [7:0] d, input int waits,
                               input bit hold, input logic [7:0] nd, input int drop_at);
        build(c, d, waits);
        foreach (exp_q[i]) begin
            @(negedge clk);
            chk("tx", tx, exp_q[i]);
            chk("ready_busy", bus.ready, 0);
            chk("done_busy", done, 0);
            if (i == 0) controls = 8'($urandom);
            if (i == drop_at) cts = 1'b0;
        end
        @(negedge clk);
        chk("done", done, 1);
        chk("ready_done", bus.ready, 1);
        controls = c;
        if (hold) bus.data = nd;
    endtask

    task automatic send(input logic [7:0] c, input logic [7:0] d);
        @(negedge clk);
        controls  = c;
        bus.data  = d;
        bus.valid = 1'b1;
        @(posedge clk);
        #1;
        bus.valid = 1'b0;
        bus.data  = 8'($urandom);
        check_frame(c, d, hs_wait(c), 1'b0, 8'd0, -1);
        @(negedge clk);
        chk("done_pulse", done, 0);
    endtask

    initial begin
        logic [7:0] c, d, d2;
        bus.valid = 1'b0;
        bus.data  = 8'd0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_tx", tx, 1);
        chk("rst_ready", bus.ready, 1);
        chk("rst_done", done, 0);

        send(8'hCC, 8'hA5);
        send(8'hEB, 8'h83);
        send(8'hC1, 8'hFF);

`ifdef UART_TX_HANDSHAKE_EN
        d = 8'($urandom);
        @(negedge clk);
        cts = 1'b0;
        controls = 8'hDC;
        bus.data = d;
        bus.valid = 1'b1;
        @(posedge clk);
        #1 bus.valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("cts_hold_tx", tx, 1);
            chk("cts_hold_ready", bus.ready, 0);
        end
        cts = 1'b1;
        check_frame(8'hDC, d, 0, 1'b0, 8'd0, 12);
        @(negedge clk);
        chk("cts_done_pulse", done, 0);
        cts = 1'b1;
`endif

        // Reset during data bit 3 of an 8N1 frame.
        d = 8'($urandom);
        @(negedge clk);
        controls = 8'hCC;
        bus.data = d;
        bus.valid = 1'b1;
        @(posedge clk);
        #1 bus.valid = 1'b0;
        repeat (17) @(negedge clk);
        chk("pre_rst_bit3", tx, d[3]);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("midrst_tx", tx, 1);
        chk("midrst_ready", bus.ready, 1);
        for (int i = 0; i < 30; i++) begin
            chk("midrst_no_done", done, 0);
            @(negedge clk);
        end
        send(8'hCC, 8'($urandom));

        // Reset and valid together: nothing accepted.
        @(negedge clk);
        rst = 1'b1;
        bus.valid = 1'b1;
        bus.data = 8'h00;
        @(posedge clk);
        #1 rst = 1'b0;
        bus.valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("rstvalid_ready", bus.ready, 1);
            chk("rstvalid_tx", tx, 1);
        end

        // Slowest rate, valid held high across two characters.
        d  = 8'($urandom);
        d2 = 8'($urandom);
        @(negedge clk);
        controls = 8'h0C;
        bus.data = d;
        bus.valid = 1'b1;
        @(posedge clk);
        #1 bus.data = 8'($urandom);
        check_frame(8'h0C, d, 0, 1'b1, d2, -1);
        @(posedge clk);
        #1 bus.valid = 1'b0;
        bus.data = 8'($urandom);
        check_frame(8'h0C, d2, 0, 1'b0, 8'd0, -1);
        @(negedge clk);
        chk("b2b_done_pulse", done, 0);

        for (int k = 0; k < 12; k++) begin
            c = 8'($urandom);
            c[7] = 1'b1;
            send(c, 8'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/uart_tx.md
# uart_tx

Configurable UART transmitter, the transmit counterpart of the UART receive path. It serializes one 5–8 bit character per request into a frame: start bit, data bits LSB first, optional even/odd parity, and 1 or 2 stop bits. The baud rate is selected at run time from 7200/9600/19200/115200. The `controls` byte uses the same field layout as the receive controller, so one register configures both directions. The baud timing comes from an internal divider clocked by the system clock; no derived clocks are used.

## Interface
- CLK_FREQ, 50_000_000, system clock frequency in Hz; bit divisor DIV = CLK_FREQ / baud, truncated integer division.
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous reset, active-high.
- controls  input  8  [7:6] baud select (00=7200, 01=9600, 10=19200, 11=115200); [5] stop bits (0=1, 1=2); [4] handshake enable; [3:2] data bits (00=5, 01=6, 10=7, 11=8); [1] parity type (1=even, 0=odd); [0] parity enable.
- data  input  8  character to send; bits above the selected width are ignored.
- valid  input  1  request to send `data`.
- ready  output  1  block can accept a request.
- cts  input  1  peer clear-to-send, active-high; used only when handshake is enabled.
- tx  output  1  serial line; idle high; registered.
- done  output  1  one-cycle pulse when the final stop bit period ends.

## Operation
- Acceptance: a request is accepted in a cycle where valid=1 and ready=1. In that cycle `data` and `controls` are latched. ready drops the next cycle. valid while ready=0 is ignored.
- Latched controls govern the whole frame. Changes on `controls` mid-frame have no effect.
- FSM states: IDLE, WAIT_CTS, START, DATA, PARITY, STOP.
  - IDLE: tx=1, ready=1. On accept → WAIT_CTS if handshake is enabled, else → START.
  - WAIT_CTS: tx=1. cts is sampled each cycle; cts=1 → START on the next cycle.
  - START: tx=0 for DIV cycles → DATA.
  - DATA: bits 0..N-1 of latched data, LSB first, DIV cycles each. N = 5 + controls[3:2]. Then → PARITY if parity is enabled, else → STOP.
  - PARITY: tx = XOR of the N sent bits when even; its complement when odd. DIV cycles → STOP.
  - STOP: tx=1 for DIV cycles (1 stop) or 2·DIV cycles (2 stops) → IDLE with done=1.
- Baud counter: loaded with DIV-1 at each bit start and counts down to 0. Bit index is 3 bits wide; stop count is 1 bit.
- cts falling after START has been entered is ignored; the frame always completes.

## Timing
- Reset values: tx=1, ready=1, done=0, FSM=IDLE, counters=0.
- Without handshake, accept at edge T: tx=0 (start bit) from cycle T+1.
- With handshake, the start bit begins the cycle after the first cycle in which cts=1 is sampled in WAIT_CTS.
- Frame length: (1 + N + P + S)·DIV cycles, where P = parity enable (0/1) and S = number of stop bits (1/2).
- done=1 and ready=1 occur in the same cycle: the first cycle after the last stop-bit cycle.
- A new accept in that cycle starts the next start bit one cycle later. Back-to-back frames therefore have no idle gap beyond the stop bits.
- rst mid-frame: on the next edge tx=1, ready=1, FSM=IDLE. done is not pulsed and the frame is lost.
- rst and valid in the same cycle: reset wins and nothing is accepted.

## Configuration
- Macro: UART_TX_HANDSHAKE_EN.
- Defined: controls[4] enables the WAIT_CTS gating described above.
- Undefined: the WAIT_CTS state and cts logic are compiled out. controls[4] and cts are ignored, and every accept goes directly to START. The cts port is still present.

## Test plan
All scenarios use CLK_FREQ=460800, giving DIV = 64 / 48 / 24 / 4.
- Basic 8N1: controls=8'hCC, data=8'hA5. tx sequence 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles. done at cycle T+41. ready low throughout the frame.
- 7 bits, even parity, 2 stop bits: controls=8'hEB, data=8'h83. Data bits 1,1,0,0,0,0,0, then parity=0, then 1,1. Frame is 44 cycles.
- 5 bits, odd parity: controls=8'hC1, data=8'hFF. Data bits 1,1,1,1,1, then parity=0, then stop=1. Frame is 32 cycles; data bits 5–7 are not sent.
- Handshake (macro defined): controls=8'hDC, cts=0 at accept. tx stays 1 for 20 cycles. Raise cts: start bit begins the next cycle. Drop cts during DATA: frame completes unchanged.
- Reset mid-frame: assert rst during data bit 3. Next cycle tx=1, ready=1; no done pulse. A following request transmits correctly.
- Slowest rate plus back-to-back: controls=8'h0C, valid held high for 2 characters. Bit period is 64 cycles and each frame is 640 cycles. The second start bit begins one cycle after the first done. valid asserted while ready=0 does not corrupt the frame.
